// File: rtl/inertial_pkg.sv
// Shared types and constants for the inertial sensor front-end sequencer:
// FSM state encoding, sensor register map, init command words and command helpers.
package inertial_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT = 4'd0,
        WR0       = 4'd1,
        WR1       = 4'd2,
        WR2       = 4'd3,
        WR3       = 4'd4,
        IDLE      = 4'd5,
        RD_PL     = 4'd6,
        RD_PH     = 4'd7,
        RD_AL     = 4'd8,
        RD_AH     = 4'd9,
        PUBLISH   = 4'd10
    } state_t;

    localparam logic       CMD_RD = 1'b1;
    localparam logic       CMD_WR = 1'b0;

    localparam logic [6:0] PTCH_L = 7'h22;
    localparam logic [6:0] PTCH_H = 7'h23;
    localparam logic [6:0] AZ_L   = 7'h2C;
    localparam logic [6:0] AZ_H   = 7'h2D;

    localparam logic [15:0] INIT_CMD0 = {CMD_WR, 7'h0D, 8'h02};
    localparam logic [15:0] INIT_CMD1 = {CMD_WR, 7'h10, 8'h53};
    localparam logic [15:0] INIT_CMD2 = {CMD_WR, 7'h11, 8'h50};
    localparam logic [15:0] INIT_CMD3 = {CMD_WR, 7'h14, 8'h60};

    function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
        return {CMD_RD, addr, 8'h00};
    endfunction

    function automatic logic [15:0] step_cmd(input state_t s);
        case (s)
            WR0:     return INIT_CMD0;
            WR1:     return INIT_CMD1;
            WR2:     return INIT_CMD2;
            WR3:     return INIT_CMD3;
            RD_PL:   return rd_cmd(PTCH_L);
            RD_PH:   return rd_cmd(PTCH_H);
            RD_AL:   return rd_cmd(AZ_L);
            RD_AH:   return rd_cmd(AZ_H);
            default: return 16'h0000;
        endcase
    endfunction

    function automatic state_t next_step(input state_t s);
        case (s)
            WR0:     return WR1;
            WR1:     return WR2;
            WR2:     return WR3;
            WR3:     return IDLE;
            RD_PL:   return RD_PH;
            RD_PH:   return RD_AL;
            RD_AL:   return RD_AH;
            RD_AH:   return PUBLISH;
            default: return INIT_WAIT;
        endcase
    endfunction

endpackage

// File: rtl/int_sync.sv
// Two-flop synchronizer bringing the asynchronous sensor interrupt into clk.
module int_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/inertial_reader.sv
// Inertial sensor sequencer: SPI init writes, then pitch-rate/Z-accel reads per interrupt.
// Optional SPI done-timeout with sticky err is enabled by defining INERT_TIMEOUT_EN.
module inertial_reader
    import inertial_pkg::*;
#(
    parameter int INIT_WAIT_W = 16,
    parameter int TMO_CYC     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ,
    output logic        err
);

    state_t                 state_r, state_nxt;
    logic [INIT_WAIT_W-1:0] wait_cnt_r;
    logic                   pend_r, pend_nxt;
    logic                   wrt_r, wrt_nxt;
    logic [15:0]            cmd_r, cmd_nxt;
    logic [7:0]             pl_r, ph_r, al_r;
    logic [15:0]            ptch_rt_r, az_r;
    logic                   vld_r;
    logic                   int_s;
    logic                   pub_s;
    logic                   tmo_hit_s;
    logic                   is_init_s;
    logic                   unused_s;

    int_sync u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (INT),
        .q   (int_s)
    );

    assign is_init_s = (state_r == WR0) || (state_r == WR1) ||
                       (state_r == WR2) || (state_r == WR3);
    assign unused_s  = (^rd_data[15:8]) ^ (TMO_CYC > 0);

    // Next-state logic; pend_r separates the wrt cycle from the wait-for-done phase.
    always_comb begin
        state_nxt = state_r;
        pend_nxt  = pend_r;
        wrt_nxt   = 1'b0;
        cmd_nxt   = cmd_r;
        pub_s     = 1'b0;
        case (state_r)
            INIT_WAIT: begin
                if (&wait_cnt_r) state_nxt = WR0;
                else             state_nxt = INIT_WAIT;
            end
            IDLE: begin
                if (int_s) state_nxt = RD_PL;
                else       state_nxt = IDLE;
            end
            PUBLISH: state_nxt = IDLE;
            WR0, WR1, WR2, WR3, RD_PL, RD_PH, RD_AL, RD_AH: begin
                if (!pend_r) begin
                    wrt_nxt  = 1'b1;
                    pend_nxt = 1'b1;
                    cmd_nxt  = step_cmd(state_r);
                end else if (done) begin
                    pend_nxt  = 1'b0;
                    state_nxt = next_step(state_r);
                    pub_s     = (state_r == RD_AH);
                end else if (tmo_hit_s) begin
                    pend_nxt  = 1'b0;
                    state_nxt = is_init_s ? WR0 : IDLE;
                end else begin
                    state_nxt = state_r;
                end
            end
            default: begin
                state_nxt = INIT_WAIT;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    // State, command and sample registers; outputs only change together on publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= INIT_WAIT;
            wait_cnt_r <= {INIT_WAIT_W{1'b0}};
            pend_r     <= 1'b0;
            wrt_r      <= 1'b0;
            cmd_r      <= 16'h0000;
            pl_r       <= 8'h00;
            ph_r       <= 8'h00;
            al_r       <= 8'h00;
            ptch_rt_r  <= 16'h0000;
            az_r       <= 16'h0000;
            vld_r      <= 1'b0;
        end else begin
            state_r <= state_nxt;
            pend_r  <= pend_nxt;
            wrt_r   <= wrt_nxt;
            cmd_r   <= cmd_nxt;
            vld_r   <= pub_s;
            if (state_r == INIT_WAIT)
                wait_cnt_r <= wait_cnt_r + {{(INIT_WAIT_W-1){1'b0}}, 1'b1};
            else
                wait_cnt_r <= {INIT_WAIT_W{1'b0}};
            if (pend_r && done) begin
                case (state_r)
                    RD_PL:   pl_r <= rd_data[7:0];
                    RD_PH:   ph_r <= rd_data[7:0];
                    RD_AL:   al_r <= rd_data[7:0];
                    default: pl_r <= pl_r;
                endcase
            end
            if (pub_s) begin
                ptch_rt_r <= {ph_r, pl_r};
                az_r      <= {rd_data[7:0], al_r};
            end
        end
    end

`ifdef INERT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;

    // Counts cycles since the last wrt; expiry abandons the step and latches err.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            err_r     <= 1'b0;
        end else begin
            if (!pend_r) tmo_cnt_r <= {TMO_W{1'b0}};
            else         tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
            if (tmo_hit_s) err_r <= 1'b1;
            else           err_r <= err_r;
        end
    end

    assign tmo_hit_s = pend_r & ~done & (tmo_cnt_r == TMO_W'(TMO_CYC - 1));
    assign err       = err_r;
`else
    assign tmo_hit_s = 1'b0;
    assign err       = 1'b0;
`endif

    assign wrt     = wrt_r;
    assign cmd     = cmd_r;
    assign vld     = vld_r;
    assign ptch_rt = ptch_rt_r;
    assign AZ      = az_r;

endmodule

// File: tb/tb_inertial_reader.sv
// Scoreboard bench for inertial_reader: SPI responder model, expected-command and
// expected-sample queues checked by an independent monitor.
module tb_inertial_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_lvl = 1'b0;
    int          int_base = 0;
    int          ah_cnt = 0;
    logic        int_pin;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt, vld, err;
    logic [15:0] cmd, ptch_rt, AZ;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_cmd_q[$];
    logic [31:0] exp_smp_q[$];
    logic [7:0]  rd_q[$];

    bit          drop_al = 1'b0;
    int          ah_done_cyc = 0;
    int          ph_cnt = 0;
    int          al_seen = 0;
    int          al_wrt_cyc = 0;
    logic [31:0] last_pub = 32'h0;

    assign int_pin = int_lvl && (ah_cnt == int_base);

    inertial_reader #(.INIT_WAIT_W(4), .TMO_CYC(20)) dut (
        .clk     (clk),
        .rst     (rst),
        .INT     (int_pin),
        .done    (done),
        .rd_data (rd_data),
        .wrt     (wrt),
        .cmd     (cmd),
        .vld     (vld),
        .ptch_rt (ptch_rt),
        .AZ      (AZ),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SPI master model: done 10 cycles after each wrt, read byte popped from rd_q.
    initial begin
        bit          pend = 1'b0;
        bit          pend_drop = 1'b0;
        int          dly = 0;
        logic [15:0] pend_cmd = 16'h0;
        logic [7:0]  b;
        forever begin
            @(posedge clk);
            #1;
            done    = 1'b0;
            rd_data = 16'h0000;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    dly--;
                    if (dly == 0) begin
                        pend = 1'b0;
                        if (!pend_drop) begin
                            b = 8'h00;
                            if (pend_cmd[15] && rd_q.size() > 0) b = rd_q.pop_front();
                            done    = 1'b1;
                            rd_data = {8'h00, b};
                            if (pend_cmd == 16'hAD00) ah_done_cyc = cyc;
                            if (pend_cmd == 16'hA300) ph_cnt++;
                        end
                    end
                end
                if (wrt) begin
                    pend      = 1'b1;
                    dly       = 10;
                    pend_cmd  = cmd;
                    pend_drop = drop_al && (cmd == 16'hAC00);
                    if (cmd == 16'hAD00) ah_cnt++;
                end
            end
        end
    end

    // Monitor: compares every wrt/cmd and every vld sample against the queues.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_pub = 32'h0;
        end else begin
            if (wrt) begin
                if (cmd == 16'hAC00) begin
                    al_wrt_cyc = cyc;
                    al_seen++;
                end
                if (exp_cmd_q.size() == 0) chk("unexpected_wrt", {16'h0, cmd}, 32'hFFFF_FFFF);
                else chk("cmd", {16'h0, cmd}, {16'h0, exp_cmd_q.pop_front()});
            end
            if (vld) begin
                chk("vld_latency", cyc, ah_done_cyc + 1);
                if (exp_smp_q.size() == 0) begin
                    chk("unexpected_vld", {ptch_rt, AZ}, 32'hFFFF_FFFF);
                end else begin
                    last_pub = exp_smp_q.pop_front();
                    chk("sample", {ptch_rt, AZ}, last_pub);
                end
            end else begin
                chk("hold", {ptch_rt, AZ}, last_pub);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_wrt", {31'h0, wrt}, 32'h0);
        chk("rst_cmd", {16'h0, cmd}, 32'h0);
        chk("rst_vld", {31'h0, vld}, 32'h0);
        chk("rst_ptch", {16'h0, ptch_rt}, 32'h0);
        chk("rst_az", {16'h0, AZ}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
    endtask

    task automatic push_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    task automatic push_reads();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
    endtask

    // Releases reset on a negedge and measures cycles to the first wrt.
    task automatic release_and_time_first_wrt();
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (wrt) break;
        end
        chk("first_wrt_latency", n, 17);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_cmd_q.size() != 0 || exp_smp_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'h0, (n >= bound)}, 32'h0);
        repeat (15) @(negedge clk);
    endtask

    task automatic run_sample(input logic [7:0] pl, ph, al, ah);
        rd_q.push_back(pl);
        rd_q.push_back(ph);
        rd_q.push_back(al);
        rd_q.push_back(ah);
        push_reads();
        exp_smp_q.push_back({ph, pl, ah, al});
        int_base = ah_cnt;
        int_lvl  = 1'b1;
        wait_drain(300);
        int_lvl  = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        // reset state and init sequence timing
        repeat (3) @(negedge clk);
        check_reset_outputs();
        push_init();
        release_and_time_first_wrt();
        wait_drain(200);

        run_sample(8'h34, 8'h12, 8'h78, 8'h56);
        run_sample(8'h00, 8'h80, 8'hFF, 8'hFF);

        // INT high through init, reset after the RD_PH done
        rst      = 1'b1;
        int_base = ah_cnt;
        int_lvl  = 1'b1;
        repeat (2) @(negedge clk);
        rd_q.delete();
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        push_init();
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        base = ph_cnt;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (ph_cnt == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ph_done_timeout", {31'h0, (n >= 300)}, 32'h0);
        @(negedge clk);
        rst     = 1'b1;
        int_lvl = 1'b0;
        chk("reads_before_rst", exp_cmd_q.size(), 0);
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rd_q.delete();
        push_init();
        release_and_time_first_wrt();
        wait_drain(200);

`ifdef INERT_TIMEOUT_EN
        // suppressed done on RD_AL: err after 20 cycles, no vld, back to IDLE
        rd_q.push_back(8'h01);
        rd_q.push_back(8'h02);
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        drop_al  = 1'b1;
        base     = al_seen;
        int_base = ah_cnt;
        int_lvl  = 1'b1;
        n = 0;
        while (al_seen == base && n < 300) begin
            @(negedge clk);
            n++;
        end
        int_lvl = 1'b0;
        chk("al_wrt_timeout", {31'h0, (n >= 300)}, 32'h0);
        n = 0;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("err_latency", cyc - al_wrt_cyc, 20);
        repeat (20) @(negedge clk);
        drop_al = 1'b0;
        rd_q.delete();
`endif

        run_sample(8'hCD, 8'hAB, 8'h01, 8'h80);
`ifdef INERT_TIMEOUT_EN
        chk("err_sticky", {31'h0, err}, 32'h1);
`else
        chk("err_tied", {31'h0, err}, 32'h0);
`endif
        chk("cmd_q_empty", exp_cmd_q.size(), 0);
        chk("smp_q_empty", exp_smp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inertial_reader.md
# inertial_reader

Front-end sequencer for the inertial sensor path. It drives the SPI master with a fixed register-write init sequence, then services each sensor data-ready interrupt by reading pitch-rate and Z-acceleration bytes. It assembles two signed 16-bit samples and presents them with a single-cycle `vld` strobe. It sits directly upstream of the pitch integrator, which consumes `vld`, `ptch_rt` and `AZ`.

## Interface

Parameters:
- `INIT_WAIT_W`, default 16: width of the power-up wait counter; the init sequence starts after 2^INIT_WAIT_W cycles.
- `TMO_CYC`, default 255: SPI done-timeout in cycles (used only with the timeout feature).

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `INT`  in  1: sensor data-ready interrupt; asynchronous, level.
- `done`  in  1: SPI master transaction-complete pulse, one cycle.
- `rd_data`  in  16: SPI master read data; valid in the `done` cycle; byte is in [7:0].
- `wrt`  out  1: one-cycle pulse that starts an SPI transaction.
- `cmd`  out  16: SPI command word; held stable from `wrt` until `done`.
- `vld`  out  1: one-cycle pulse; new `ptch_rt`/`AZ` are valid.
- `ptch_rt`  out  16: signed pitch rate, {high byte, low byte}.
- `AZ`  out  16: signed Z acceleration, {high byte, low byte}.
- `err`  out  1: sticky SPI timeout flag; tied to 0 without the macro.

## Operation

- `INT` passes through a two-flop synchronizer before use; its synced output is `int_s`.
- Command format:
  - read: {1'b1, addr[6:0], 8'h00}
  - write: {1'b0, addr[6:0], data[7:0]}
- State machine, entered from reset in INIT_WAIT:
  - INIT_WAIT: the counter increments each cycle. When it reaches all-ones, go to WR0.
  - WR0..WR3: issue writes 16'h0D02, 16'h1053, 16'h1150 and 16'h1460 in order.
  - IDLE: when `int_s`=1, go to RD_PL.
  - RD_PL, RD_PH, RD_AL, RD_AH: issue reads of addresses 7'h22, 7'h23, 7'h2C and 7'h2D. Each returned byte goes to a holding register.
  - PUBLISH: load the outputs, pulse `vld`, and return to IDLE.
- Each command step takes one cycle for the `wrt` pulse, then waits for `done` with `wrt` low. On `done`, the machine advances to the next step and issues its `wrt` in the following cycle.
- `INT` is ignored outside IDLE.
  - An interrupt that arrives mid-read is serviced only if `int_s` is still high on return to IDLE.
  - The sensor clears `INT` when the data is read.
- A `done` with no outstanding command is ignored.
- `ptch_rt` and `AZ` update only in PUBLISH, both together. Partial samples are never visible.
- No arithmetic is performed; bytes are concatenated only. Sign is carried by the high byte.

## Timing

- Reset values: `wrt`=0, `cmd`=0, `vld`=0, `ptch_rt`=0, `AZ`=0, `err`=0. State is INIT_WAIT; the counter, synchronizer flops and holding registers are all 0.
- Reset mid-operation overrides everything: an in-flight transaction is abandoned and the init sequence reruns in full.
- First `wrt` occurs 2^INIT_WAIT_W + 1 cycles after reset deasserts.
- Interrupt latency: `int_s` rises 2 cycles after `INT`. The first read `wrt` follows 1 cycle after IDLE sees `int_s`.
- `vld` rises 1 cycle after the `done` for the RD_AH read. The new output values are registered in that same cycle.
- `vld` stays high for exactly one cycle per sample. There is no back-pressure.

## Configuration

- Macro `INERT_TIMEOUT_EN`.
- Defined:
  - A per-command counter starts at each `wrt`.
  - If `done` has not arrived after TMO_CYC cycles, set `err` (sticky until `rst`), abandon the step and return to IDLE without a `vld`.
  - During init, a timeout instead restarts at WR0.
- Undefined:
  - There is no counter; the machine waits for `done` indefinitely.
  - `err` is constant 0.

## Structure

- Package `inertial_pkg` holds:
  - the state enum;
  - the register address localparams (PTCH_L/H, AZ_L/H);
  - the four init command words;
  - the read/write command-bit constant.
- Sub-module `int_sync` is the two-flop `INT` synchronizer, which has synchronous active-high reset.
- Everything else stays in one file.

## Test plan

- Reset held, then released: all outputs are 0. No `wrt` occurs for 2^INIT_WAIT_W cycles (set INIT_WAIT_W=4 in the bench), and the first `cmd` is 16'h0D02.
- Run init with an SPI model that returns `done` 10 cycles after each `wrt`: exactly four `wrt` pulses carrying 16'h0D02, 16'h1053, 16'h1150, 16'h1460; none carry the read bit.
- After init, raise `INT` with the model returning bytes 0x34, 0x12, 0x78, 0x56:
  - read `cmd` sequence is 16'hA200, 16'hA300, 16'hAC00, 16'hAD00;
  - `vld` pulses once with `ptch_rt`=16'h1234 and `AZ`=16'h5678.
- Return bytes 0x00, 0x80, 0xFF, 0xFF: `ptch_rt`=16'h8000 and `AZ`=16'hFFFF. Previous values hold until `vld`.
- Hold `INT` high through init, then assert `rst` after the RD_PH `done`:
  - no read is issued before IDLE;
  - after reset, outputs return to 0 and init restarts from INIT_WAIT.
- With `INERT_TIMEOUT_EN` defined and `TMO_CYC`=20, suppress the `done` for RD_AL: `err` rises 20 cycles after `wrt`, there is no `vld`, and the state returns to IDLE.
